// File: rtl/sram_mask_port_if.sv
// sram_mask_port_if: request/response channels between a memory client and sram_mask_port
interface sram_mask_port_if #(
   parameter int DATA_W    = 7,
   parameter int ADDR_W    = 6,
   parameter int RSP_DEPTH = 2
);
   localparam int CW = $clog2(RSP_DEPTH + 1);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [DATA_W-1:0] req_wmask;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic [CW-1:0]     rsp_count;
   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_count
   );
   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_count
   );
endinterface

// File: rtl/sram_mask_port.sv
// sram_mask_port: bit-masked single-port memory with back-pressured request and buffered read responses
module sram_mask_port #(
   parameter int DATA_W    = 7,
   parameter int ADDR_W    = 6,
   parameter int DEPTH     = 64,
   parameter int RSP_DEPTH = 2
) (
   input logic             clk,
   input logic             rst_n,
   sram_mask_port_if.slave bus
);
   localparam int CW = $clog2(RSP_DEPTH + 1);
   localparam int PW = RSP_DEPTH > 1 ? $clog2(RSP_DEPTH) : 1;
   logic [DATA_W-1:0] mem    [DEPTH];
   logic [DATA_W-1:0] fifo_d [RSP_DEPTH];
   logic              fifo_e [RSP_DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count;
   logic              in_range, push, pop;
   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return p == PW'(RSP_DEPTH - 1) ? '0 : p + 1'b1;
   endfunction
   assign in_range      = {1'b0, bus.req_addr} < (ADDR_W + 1)'(DEPTH);
   assign bus.req_ready = bus.req_we | (count < CW'(RSP_DEPTH));
   assign push          = bus.req_valid & bus.req_ready & ~bus.req_we;
   assign pop           = bus.rsp_valid & bus.rsp_ready;
   assign bus.rsp_valid = count != '0;
   assign bus.rsp_count = count;
   assign bus.rsp_rdata = fifo_d[rd_ptr];
   assign bus.rsp_err   = fifo_e[rd_ptr];
   // Array is deliberately not reset so it maps onto a plain macro.
   always_ff @(posedge clk) begin
      if (bus.req_valid & bus.req_we & in_range)
         mem[bus.req_addr] <= (mem[bus.req_addr] & ~bus.req_wmask) | (bus.req_wdata & bus.req_wmask);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < RSP_DEPTH; i++) begin
            fifo_d[i] <= '0;
            fifo_e[i] <= 1'b0;
         end
      end else begin
         if (push) begin
            fifo_d[wr_ptr] <= in_range ? mem[bus.req_addr] : '0;
            fifo_e[wr_ptr] <= ~in_range;
            wr_ptr         <= nxt(wr_ptr);
         end
         if (pop) rd_ptr <= nxt(rd_ptr);
         count <= count + CW'(push) - CW'(pop);
      end
   end
endmodule

// File: tb/tb_sram_mask_port.sv
// tb_sram_mask_port: directed scoreboard bench for a 64-deep and a 48-deep sram_mask_port
module tb_sram_mask_port;
   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad = 0;
   logic [6:0] model [64];
   logic [7:0] qa [$];
   logic [7:0] qb [$];
   logic [7:0] exp_v;
   always #5 clk = ~clk;
   sram_mask_port_if #(.DATA_W(7), .ADDR_W(6), .RSP_DEPTH(2)) a ();
   sram_mask_port_if #(.DATA_W(7), .ADDR_W(6), .RSP_DEPTH(2)) b ();
   sram_mask_port #(.DATA_W(7), .ADDR_W(6), .DEPTH(64), .RSP_DEPTH(2)) u_a (.clk(clk), .rst_n(rst_n), .bus(a.slave));
   sram_mask_port #(.DATA_W(7), .ADDR_W(6), .DEPTH(48), .RSP_DEPTH(2)) u_b (.clk(clk), .rst_n(rst_n), .bus(b.slave));

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   task automatic mon();
      if (a.rsp_valid && a.rsp_ready) begin
         if (qa.size() == 0) chk("a_unexpected_rsp", {a.rsp_err, a.rsp_rdata}, 8'hxx);
         else begin
            exp_v = qa.pop_front();
            chk("a_rsp", {a.rsp_err, a.rsp_rdata}, exp_v);
         end
      end
      if (b.rsp_valid && b.rsp_ready) begin
         if (qb.size() == 0) chk("b_unexpected_rsp", {b.rsp_err, b.rsp_rdata}, 8'hxx);
         else begin
            exp_v = qb.pop_front();
            chk("b_rsp", {b.rsp_err, b.rsp_rdata}, exp_v);
         end
      end
   endtask

   task automatic neg();
      @(negedge clk);
      mon();
   endtask

   task automatic pos();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic we, input logic [5:0] ad, input logic [6:0] wd, input logic [6:0] wm);
      a.req_valid = 1'b1;
      a.req_we    = we;
      a.req_addr  = ad;
      a.req_wdata = wd;
      a.req_wmask = wm;
      for (int n = 0; n <= 20; n++) begin
         neg();
         if (a.req_ready) break;
         if (n == 20) chk("req_accept_timeout", 8'(a.req_ready), 8'h01);
         pos();
      end
      if (we) model[ad] = (model[ad] & ~wm) | (wd & wm);
      else qa.push_back({1'b0, model[ad]});
      pos();
      a.req_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      {a.req_valid, a.req_we, a.req_addr, a.req_wdata, a.req_wmask} = '0;
      {b.req_valid, b.req_we, b.req_addr, b.req_wdata, b.req_wmask} = '0;
      a.rsp_ready = 1'b1;
      b.rsp_ready = 1'b1;
      #2;
      chk("reset_valid", 8'(a.rsp_valid), 8'h00);
      chk("reset_count", 8'(a.rsp_count), 8'h00);
      chk("reset_rdata", 8'(a.rsp_rdata), 8'h00);
      chk("reset_err", 8'(a.rsp_err), 8'h00);
      chk("reset_ready", 8'(a.req_ready), 8'h01);
      pos(); pos();
      rst_n = 1'b1;
      pos();
      // full write then read, one-cycle latency
      req(1'b1, 6'd5, 7'h55, 7'h7F);
      req(1'b0, 6'd5, 7'h00, 7'h00);
      neg();
      chk("t1_latency_valid", 8'(a.rsp_valid), 8'h01);
      pos();
      // partial mask merge
      req(1'b1, 6'd5, 7'h2A, 7'h0F);
      req(1'b0, 6'd5, 7'h00, 7'h00);
      neg();
      chk("t2_merge_rdata", 8'(a.rsp_rdata), 8'h5A);
      pos();
      for (int i = 0; i < 64; i++) req(1'b1, 6'(i), 7'(i) ^ 7'h3C, 7'h7F);
      // back-pressure: reads stall when full, writes do not
      a.rsp_ready = 1'b0;
      req(1'b0, 6'd0, 7'h00, 7'h00);
      req(1'b0, 6'd1, 7'h00, 7'h00);
      neg();
      chk("t3_count_full", 8'(a.rsp_count), 8'h02);
      a.req_valid = 1'b1;
      a.req_we    = 1'b0;
      a.req_addr  = 6'd2;
      #1;
      chk("t3_read_stalled", 8'(a.req_ready), 8'h00);
      pos();
      req(1'b1, 6'd10, 7'h7F, 7'h00);
      neg();
      chk("t3_count_after_write", 8'(a.rsp_count), 8'h02);
      chk("t3_head_held", {a.rsp_err, a.rsp_rdata}, 8'h3C);
      pos();
      a.rsp_ready = 1'b1;
      req(1'b0, 6'd2, 7'h00, 7'h00);
      neg(); pos(); neg(); pos();
      chk("t3_drained", 8'(qa.size()), 8'h00);
      // streaming reads
      a.req_valid = 1'b1;
      a.req_we    = 1'b0;
      for (int i = 0; i < 64; i++) begin
         a.req_addr = 6'(i);
         neg();
         chk("t4_ready", 8'(a.req_ready), 8'h01);
         if (i > 0) chk("t4_count", 8'(a.rsp_count), 8'h01);
         qa.push_back({1'b0, model[i]});
         pos();
      end
      a.req_valid = 1'b0;
      neg(); pos();
      chk("t4_drained", 8'(qa.size()), 8'h00);
      chk("t4_count_end", 8'(a.rsp_count), 8'h00);
      // out-of-range on the 48-deep instance
      b.req_valid = 1'b1;
      b.req_we    = 1'b1;
      b.req_addr  = 6'd50;
      b.req_wdata = 7'h11;
      b.req_wmask = 7'h7F;
      neg();
      chk("t5_write_ready", 8'(b.req_ready), 8'h01);
      pos();
      b.req_addr  = 6'd47;
      b.req_wdata = 7'h2B;
      neg(); pos();
      b.req_we   = 1'b0;
      b.req_addr = 6'd50;
      qb.push_back(8'h80);
      neg(); pos();
      b.req_addr = 6'd47;
      qb.push_back(8'h2B);
      neg(); pos();
      b.req_valid = 1'b0;
      neg(); pos();
      chk("t5_drained", 8'(qb.size()), 8'h00);
      // reset mid-stream empties the FIFO but keeps memory
      a.rsp_ready = 1'b0;
      req(1'b0, 6'd3, 7'h00, 7'h00);
      req(1'b0, 6'd4, 7'h00, 7'h00);
      neg();
      chk("t6_count_full", 8'(a.rsp_count), 8'h02);
      pos();
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 8'(a.rsp_valid), 8'h00);
      chk("t6_rst_count", 8'(a.rsp_count), 8'h00);
      qa.delete();
      pos();
      rst_n = 1'b1;
      a.rsp_ready = 1'b1;
      pos();
      req(1'b0, 6'd5, 7'h00, 7'h00);
      neg(); pos();
      chk("t6_drained", 8'(qa.size()), 8'h00);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
